// File: rtl/conv_pixel_feeder.sv
// Pixel source for the 3x3 convolutor: walks a row-major feature map in a sync-read
// buffer and emits a gap-free stream framed by zero padding rows, plus window side-band flags.
module conv_pixel_feeder #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int ADDR_W       = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          width,
    input  logic [7:0]          height,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic signed [7:0]   mem_rdata,
    output logic signed [7:0]   pixel_out,
    output logic                pixel_vld,
    output logic                paddingl,
    output logic                paddingr,
    output logic                win_vld,
    output logic [1:0]          operation,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        FETCH,
        FLUSH,
        DONE
    } state_t;

    state_t state, state_n;

    logic [15:0]       cnt;
    logic [15:0]       idx;
    logic [7:0]        w_q;
    logic [15:0]       wh_q;
    logic [ADDR_W-1:0] base_q;

    logic        src_mem;
    logic [7:0]  col;

    logic        size_ok;
    logic        issue;
    logic        win_issue;
    logic [15:0] w_m1;
    logic [15:0] wh_m1;
    logic [16:0] win_lo;
    logic [16:0] win_hi;

    // Frames that are empty or exceed the supported map size produce no reads at all.
    assign size_ok = (width != 8'd0) && (height != 8'd0) &&
                     ({1'b0, width}  <= 9'(IMAGE_WIDTH)) &&
                     ({1'b0, height} <= 9'(IMAGE_HEIGHT));

    assign w_m1   = {8'd0, w_q} - 16'd1;
    assign wh_m1  = wh_q - 16'd1;
    assign issue  = (state == PRIME) || (state == FETCH) || (state == FLUSH);

    // A window centred on pixel k completes once the pixel one row and one column later arrives.
    assign win_lo    = {8'd0, w_q, 1'b0} + 17'd1;
    assign win_hi    = {8'd0, w_q, 1'b0} + {1'b0, wh_q};
    assign win_issue = issue && ({1'b0, idx} >= win_lo) && ({1'b0, idx} <= win_hi);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = size_ok ? PRIME : DONE;
            PRIME:   if (cnt == w_m1) state_n = FETCH;
            FETCH:   if (cnt == wh_m1) state_n = FLUSH;
            FLUSH:   if (cnt == {8'd0, w_q}) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 16'd0;
            idx    <= 16'd0;
            w_q    <= 8'd0;
            wh_q   <= 16'd0;
            base_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                cnt <= 16'd0;
                idx <= 16'd0;
                if (start) begin
                    w_q    <= width;
                    wh_q   <= 16'(width) * 16'(height);
                    base_q <= base_addr;
                end
            end else begin
                cnt <= (state_n != state) ? 16'd0 : cnt + 16'd1;
                idx <= issue ? idx + 16'd1 : 16'd0;
            end
        end
    end

    assign mem_rd_en = (state == FETCH);
    assign mem_addr  = (state == FETCH) ? base_q + ADDR_W'(cnt) : '0;

    // Single output stage: the source select travels with the issue strobe so the
    // registered select lines up with the buffer's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_vld <= 1'b0;
            src_mem   <= 1'b0;
            win_vld   <= 1'b0;
            col       <= 8'd0;
            done      <= 1'b0;
        end else begin
            pixel_vld <= issue;
            src_mem   <= (state == FETCH);
            win_vld   <= win_issue;
            done      <= (state == DONE);
            if (win_issue && win_vld) begin
                col <= (col == w_q - 8'd1) ? 8'd0 : col + 8'd1;
            end else begin
                col <= 8'd0;
            end
        end
    end

    assign pixel_out = src_mem ? mem_rdata : 8'sd0;
    assign paddingl  = win_vld && (col == 8'd0);
    assign paddingr  = win_vld && (col == w_q - 8'd1);
    assign busy      = (state != IDLE);
    assign operation = busy ? 2'd0 : 2'd1;

endmodule

// File: tb/tb_conv_pixel_feeder.sv
// Self-checking bench for conv_pixel_feeder: table-driven and random frames compared
// cycle by cycle against an arithmetic model of the stream, plus reset and back-to-back sequences.
module tb_conv_pixel_feeder;

    localparam int AW   = 14;
    localparam int MSIZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    width = 8'd0;
    logic [7:0]    height = 8'd0;
    logic [AW-1:0] base_addr = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'd0;
    logic [7:0]    pixel_out;
    logic          pixel_vld;
    logic          paddingl;
    logic          paddingr;
    logic          win_vld;
    logic [1:0]    operation;
    logic          busy;
    logic          done;

    logic [7:0] mem [0:MSIZ-1];

    int total = 0;
    int bad = 0;

    conv_pixel_feeder #(.IMAGE_WIDTH(128), .IMAGE_HEIGHT(128), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .width(width), .height(height),
        .base_addr(base_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .pixel_out(pixel_out), .pixel_vld(pixel_vld),
        .paddingl(paddingl), .paddingr(paddingr), .win_vld(win_vld),
        .operation(operation), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Sync-read buffer: data appears one clock after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        int w;
        int h;
        int base;
        bit countFill;
        int expVld;
    } frame_t;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_vld"}, int'(pixel_vld), 0);
        checkOutput({tag, "_pix"}, int'(pixel_out), 0);
        checkOutput({tag, "_rd"}, int'(mem_rd_en), 0);
        checkOutput({tag, "_addr"}, int'(mem_addr), 0);
        checkOutput({tag, "_win"}, int'(win_vld), 0);
        checkOutput({tag, "_padl"}, int'(paddingl), 0);
        checkOutput({tag, "_padr"}, int'(paddingr), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_op"}, int'(operation), 1);
    endtask

    // Runs one frame and compares every cycle against the stream rules:
    // cycle n counts clocks after the start edge; the issue index equals n, output lags by one.
    task automatic applyStimulus(input int w, input int h, input int base, input bit countFill,
                                 input int expVld);
        int wh, npix, s, j, vldCount;
        bit zero;
        int eVld, ePix, eRd, eAddr, eWin, eL, eR, eDone, eBusy;
        wh = w * h;
        zero = (w == 0) || (h == 0);
        npix = zero ? 0 : 2 * w + wh + 1;
        for (int k = 0; k < wh; k++) begin
            mem[(base + k) % MSIZ] = countFill ? 8'(k + 1) : 8'($urandom);
        end
        @(negedge clk);
        width = 8'(w);
        height = 8'(h);
        base_addr = AW'(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vldCount = 0;
        for (int n = 0; n <= npix + 3; n++) begin
            s = n - 1;
            eVld = (!zero && n >= 1 && n <= npix) ? 1 : 0;
            ePix = (eVld == 1 && s >= w && s < w + wh) ? int'(mem[(base + s - w) % MSIZ]) : 0;
            eRd = (!zero && n >= w && n < w + wh) ? 1 : 0;
            eAddr = (eRd == 1) ? (base + n - w) % MSIZ : 0;
            eWin = (eVld == 1 && s >= 2 * w + 1 && s <= 2 * w + wh) ? 1 : 0;
            j = s - (2 * w + 1);
            eL = (eWin == 1 && (j % w) == 0) ? 1 : 0;
            eR = (eWin == 1 && (j % w) == w - 1) ? 1 : 0;
            eDone = zero ? (n == 1 ? 1 : 0) : (n == npix + 1 ? 1 : 0);
            eBusy = zero ? (n == 0 ? 1 : 0) : (n <= npix ? 1 : 0);
            checkOutput($sformatf("vld@%0d", n), int'(pixel_vld), eVld);
            checkOutput($sformatf("pix@%0d", n), int'(pixel_out), ePix);
            checkOutput($sformatf("rd@%0d", n), int'(mem_rd_en), eRd);
            if (eRd == 1) checkOutput($sformatf("addr@%0d", n), int'(mem_addr), eAddr);
            checkOutput($sformatf("win@%0d", n), int'(win_vld), eWin);
            checkOutput($sformatf("padl@%0d", n), int'(paddingl), eL);
            checkOutput($sformatf("padr@%0d", n), int'(paddingr), eR);
            checkOutput($sformatf("done@%0d", n), int'(done), eDone);
            checkOutput($sformatf("busy@%0d", n), int'(busy), eBusy);
            checkOutput($sformatf("op@%0d", n), int'(operation), eBusy ? 0 : 1);
            if (pixel_vld) vldCount++;
            @(negedge clk);
        end
        checkOutput($sformatf("vldcount_%0dx%0d", w, h), vldCount, expVld);
    endtask

    initial begin
        frame_t vec[6];
        int w, h, n, vldCount, doneCount, firstDone, secondDone;
        bit seenRd;

        vec[0] = '{w: 4, h: 3, base: 'h010,  countFill: 1'b1, expVld: 21};
        vec[1] = '{w: 0, h: 5, base: 'h020,  countFill: 1'b0, expVld: 0};
        vec[2] = '{w: 2, h: 2, base: 'h3FFE, countFill: 1'b0, expVld: 9};
        vec[3] = '{w: 1, h: 4, base: 'h100,  countFill: 1'b0, expVld: 7};
        vec[4] = '{w: 3, h: 1, base: 'h200,  countFill: 1'b0, expVld: 10};
        vec[5] = '{w: 5, h: 5, base: 'h3FF0, countFill: 1'b0, expVld: 36};

        for (int k = 0; k < MSIZ; k++) mem[k] = 8'd0;

        #1;
        checkIdleOutputs("rst0");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vec[i].w, vec[i].h, vec[i].base, vec[i].countFill, vec[i].expVld);
        end

        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(1, 12);
            h = $urandom_range(1, 10);
            applyStimulus(w, h, int'($urandom_range(0, MSIZ - 1)), 1'b0, 2 * w + w * h + 1);
        end

        // Reset in the middle of FETCH: everything drops at once and no done follows.
        @(negedge clk);
        width = 8'd4;
        height = 8'd4;
        base_addr = AW'(16'h40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seenRd = 1'b0;
        for (int c = 0; c < 50 && !seenRd; c++) begin
            if (mem_rd_en) seenRd = 1'b1;
            else @(negedge clk);
        end
        checkOutput("rd_seen_before_reset", int'(seenRd), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        vldCount = 0;
        doneCount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pixel_vld) vldCount++;
            if (done) doneCount++;
        end
        checkOutput("postrst_vld", vldCount, 0);
        checkOutput("postrst_done", doneCount, 0);

        // start held high through one frame plus its done cycle: exactly two back-to-back frames.
        w = 3;
        h = 2;
        n = 2 * w + w * h + 1;
        @(negedge clk);
        width = 8'(w);
        height = 8'(h);
        base_addr = AW'(16'h300);
        start = 1'b1;
        @(negedge clk);
        vldCount = 0;
        doneCount = 0;
        firstDone = -1;
        secondDone = -1;
        for (int c = 0; c <= 2 * n + 10; c++) begin
            if (pixel_vld) vldCount++;
            if (done) begin
                doneCount++;
                if (firstDone < 0) firstDone = c;
                else if (secondDone < 0) secondDone = c;
            end
            if (c == n + 2) start = 1'b0;
            @(negedge clk);
        end
        checkOutput("b2b_vldcount", vldCount, 2 * n);
        checkOutput("b2b_donecount", doneCount, 2);
        checkOutput("b2b_done1", firstDone, n + 1);
        checkOutput("b2b_done2", secondDone, 2 * n + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
